uart_imem_loader: RTL and testbench

Serial boot loader that receives a program image over a UART line and writes it word-by-word into instruction memory through a synchronous write port. It sits beside the instruction memory in `soc`. It holds the core in reset while an image is arriving, so new programs load without resynthesis. It is the writer side of the instruction-memory interface whose reader is the core fetch path (`InstrF = memory[PCF[31:2]]`).

---
 rtl/skylark_pkg.sv | 21 ++
 rtl/uart_rx_byte.sv | 98 +++++++++
 rtl/uart_imem_loader.sv | 133 +++++++++++++
 tb/tb_uart_imem_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/skylark_pkg.sv
// Shared types and constants for the UART instruction-memory boot loader.
package skylark_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;
    localparam logic [7:0]  LOADER_HDR           = 8'hA5;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_COUNT,
        LD_DATA,
        LD_CHECK
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte_valid or stop_err.
module uart_rx_byte
    import skylark_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic            rx_meta;
    logic            rx_sync;
    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;

    // Synchronizer flops idle high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            byte_data  <= '0;
            stop_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            stop_err   <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        // Line back high at half-bit: a glitch, not a start bit
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shreg;
                        end else begin
                            stop_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// UART boot loader writing a program image into instruction memory while holding the core in reset.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module uart_imem_loader
    import skylark_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned IMEM_DEPTH   = 32,
    parameter int unsigned AW           = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          core_hold,
    output logic          busy,
    output logic          done,
    output logic          frame_err,
    output logic          count_err,
    output logic          chk_err
);

    localparam int unsigned CW = AW + 1;

    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_stop_err;

    loader_state_t state;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   word_asm;
    logic [7:0]    csum;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .byte_valid(rx_valid),
        .byte_data (rx_data),
        .stop_err  (rx_stop_err)
    );

    assign busy = (state != LD_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LD_IDLE;
            word_cnt   <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            word_asm   <= '0;
            csum       <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            core_hold  <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            count_err  <= 1'b0;
            chk_err    <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            // A bad stop bit aborts any load; core_hold is left as-is
            if (rx_stop_err) begin
                frame_err <= 1'b1;
                state     <= LD_IDLE;
            end else if (rx_valid) begin
                unique case (state)
                    LD_IDLE: begin
                        if (rx_data == LOADER_HDR) begin
                            frame_err <= 1'b0;
                            count_err <= 1'b0;
                            chk_err   <= 1'b0;
                            done      <= 1'b0;
                            state     <= LD_COUNT;
                        end
                    end
                    LD_COUNT: begin
                        if (rx_data != 8'd0 && 32'(rx_data) <= IMEM_DEPTH) begin
                            core_hold <= 1'b1;
                            word_cnt  <= CW'(rx_data);
                            word_idx  <= '0;
                            byte_idx  <= '0;
                            csum      <= '0;
                            state     <= LD_DATA;
                        end else begin
                            count_err <= 1'b1;
                            state     <= LD_IDLE;
                        end
                    end
                    LD_DATA: begin
                        csum     <= csum ^ rx_data;
                        byte_idx <= byte_idx + 2'd1;
                        word_asm <= {rx_data, word_asm[23:8]};
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_waddr <= word_idx[AW-1:0];
                            imem_wdata <= {rx_data, word_asm};
                            word_idx   <= word_idx + CW'(1);
                            if (word_idx + CW'(1) == word_cnt) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= LD_CHECK;
`else
                                done      <= 1'b1;
                                core_hold <= 1'b0;
                                state     <= LD_IDLE;
`endif
                            end
                        end
                    end
                    LD_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                        if (rx_data == csum) begin
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            chk_err <= 1'b1;
                        end
`endif
                        state <= LD_IDLE;
                    end
                    default: state <= LD_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed self-checking bench for uart_imem_loader at CLKS_PER_BIT=4.
module tb_uart_imem_loader;

    localparam int unsigned CPB = 4;
    localparam int unsigned DEPTH = 32;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        imem_we;
    logic [4:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        frame_err;
    logic        count_err;
    logic        chk_err;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [4:0]  wa[$];
    logic [31:0] wd[$];
    int          nvalid = 0;

    uart_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .IMEM_DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .imem_we   (imem_we),
        .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata),
        .core_hold (core_hold),
        .busy      (busy),
        .done      (done),
        .frame_err (frame_err),
        .count_err (count_err),
        .chk_err   (chk_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wa.push_back(imem_waddr);
            wd.push_back(imem_wdata);
        end
        if (dut.rx_valid === 1'b1) nvalid++;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_seq(input byte_q_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        int nw;
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({imem_we, imem_waddr, imem_wdata, core_hold, busy, done, frame_err, count_err, chk_err} !== '0)
            $display("FAIL reset_outputs got we=%b wa=%h wd=%h hold=%b busy=%b done=%b fe=%b ce=%b ke=%b required all 0",
                     imem_we, imem_waddr, imem_wdata, core_hold, busy, done, frame_err, count_err, chk_err);
        else pass_cnt++;
        wa.delete(); wd.delete();
        repeat (200) @(negedge clk);
        nw = wa.size();
        total_cnt++;
        if (nw !== 0) $display("FAIL reset_idle_writes got %0d required 0", nw);
        else pass_cnt++;
    endtask

    task automatic check_two_writes(input string tag);
        int nw;
        nw = wa.size();
        total_cnt++;
        if (nw !== 2 || wa[0] !== 5'd0 || wd[0] !== 32'h00F00093 || wa[1] !== 5'd1 || wd[1] !== 32'h00110113)
            $display("FAIL %s_writes got n=%0d first=(%h,%h) second=(%h,%h) required (00,00f00093) (01,00110113)",
                     tag, nw, (nw > 0) ? wa[0] : 5'h1f, (nw > 0) ? wd[0] : 32'hx,
                     (nw > 1) ? wa[1] : 5'h1f, (nw > 1) ? wd[1] : 32'hx);
        else pass_cnt++;
    endtask

    task automatic test_load;
        byte_q_t q;
        wa.delete(); wd.delete();
        q = {8'hA5, 8'h02, 8'h93};
        foreach (q[i]) send_byte(q[i], 1'b1);
        repeat (2) @(negedge clk);
        total_cnt++;
        if (core_hold !== 1'b1 || busy !== 1'b1)
            $display("FAIL load_hold_midway got hold=%b busy=%b required 1 1", core_hold, busy);
        else pass_cnt++;
        q = {8'h00, 8'hF0, 8'h00, 8'h13, 8'h01, 8'h11, 8'h00, 8'h60};
        send_seq(q);
        check_two_writes("load");
        total_cnt++;
        if ({done, core_hold, busy, frame_err, count_err, chk_err} !== 6'b100000)
            $display("FAIL load_status got done=%b hold=%b busy=%b fe=%b ce=%b ke=%b required 1 0 0 0 0 0",
                     done, core_hold, busy, frame_err, count_err, chk_err);
        else pass_cnt++;
    endtask

    task automatic test_chk_err;
        byte_q_t q;
        wa.delete(); wd.delete();
        q = {8'hA5, 8'h02, 8'h93, 8'h00, 8'hF0, 8'h00, 8'h13, 8'h01, 8'h11, 8'h00, 8'h61};
        send_seq(q);
        check_two_writes("chk");
`ifdef LOADER_CHECKSUM_EN
        total_cnt++;
        if ({chk_err, done, core_hold} !== 3'b101)
            $display("FAIL chk_bad_status got chk=%b done=%b hold=%b required 1 0 1", chk_err, done, core_hold);
        else pass_cnt++;
        q = {8'hA5, 8'h02, 8'h93, 8'h00, 8'hF0, 8'h00, 8'h13, 8'h01, 8'h11, 8'h00, 8'h60};
        send_seq(q);
        total_cnt++;
        if ({chk_err, done, core_hold} !== 3'b010)
            $display("FAIL chk_recover_status got chk=%b done=%b hold=%b required 0 1 0", chk_err, done, core_hold);
        else pass_cnt++;
`else
        total_cnt++;
        if ({chk_err, done, core_hold} !== 3'b010)
            $display("FAIL chk_off_status got chk=%b done=%b hold=%b required 0 1 0", chk_err, done, core_hold);
        else pass_cnt++;
`endif
    endtask

    task automatic test_count_err;
        byte_q_t q;
        int nw;
        for (int k = 0; k < 2; k++) begin
            wa.delete(); wd.delete();
            q = {8'hA5, (k == 0) ? 8'h21 : 8'h00};
            send_seq(q);
            nw = wa.size();
            total_cnt++;
            if ({count_err, core_hold, done, busy} !== 4'b1000 || nw !== 0)
                $display("FAIL count_err_%0d got ce=%b hold=%b done=%b busy=%b writes=%0d required 1 0 0 0 0",
                         k, count_err, core_hold, done, busy, nw);
            else pass_cnt++;
        end
    endtask

    task automatic test_frame_err;
        byte_q_t q;
        int nw;
        wa.delete(); wd.delete();
        q = {8'hA5, 8'h01, 8'h13};
        foreach (q[i]) send_byte(q[i], 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (12 * CPB) @(negedge clk);
        total_cnt++;
        if ({frame_err, busy, core_hold, done} !== 4'b1010)
            $display("FAIL frame_status got fe=%b busy=%b hold=%b done=%b required 1 0 1 0",
                     frame_err, busy, core_hold, done);
        else pass_cnt++;
        q = {8'h00, 8'h00};
        send_seq(q);
        nw = wa.size();
        total_cnt++;
        if (nw !== 0 || busy !== 1'b0)
            $display("FAIL frame_no_writes got writes=%0d busy=%b required 0 0", nw, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        byte_q_t q;
        q = {8'hA5, 8'h02, 8'h93, 8'h00, 8'hF0, 8'h00, 8'h13, 8'h01};
        foreach (q[i]) send_byte(q[i], 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total_cnt++;
        if ({imem_we, imem_waddr, imem_wdata, core_hold, busy, done, frame_err, count_err, chk_err} !== '0)
            $display("FAIL reset_mid_outputs got we=%b wa=%h wd=%h hold=%b busy=%b done=%b required all 0",
                     imem_we, imem_waddr, imem_wdata, core_hold, busy, done);
        else pass_cnt++;
        wa.delete(); wd.delete();
        q = {8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        send_seq(q);
        total_cnt++;
        if (wa.size() !== 1 || wa[0] !== 5'd0 || wd[0] !== 32'h00000013)
            $display("FAIL fresh_write got n=%0d first=(%h,%h) required (00,00000013)", wa.size(),
                     (wa.size() > 0) ? wa[0] : 5'h1f, (wd.size() > 0) ? wd[0] : 32'hx);
        else pass_cnt++;
        total_cnt++;
        if ({done, core_hold} !== 2'b10)
            $display("FAIL fresh_status got done=%b hold=%b required 1 0", done, core_hold);
        else pass_cnt++;
    endtask

    task automatic test_glitch;
        int nv0;
        int nv1;
        nv0 = nvalid;
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        nv1 = nvalid;
        total_cnt++;
        if (nv1 !== nv0 || {frame_err, busy, done} !== 3'b001)
            $display("FAIL glitch got bytes=%0d fe=%b busy=%b done=%b required 0 0 0 1",
                     nv1 - nv0, frame_err, busy, done);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        test_reset;
        test_load;
        test_chk_err;
        test_count_err;
        test_frame_err;
        test_reset_mid;
        test_glitch;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
